// File: rtl/sensor_fifo_pkg.sv
// Shared definitions for the sensor FIFO family: depth derivation, clog2 helper
// and default flag thresholds.
package sensor_fifo_pkg;

    localparam int DEFAULT_LOGSIZE   = 4;
    localparam int DEFAULT_AF_MARGIN = 2;
    localparam int DEFAULT_AE_THRESH = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Every FIFO and its instantiating modules derive depth through this.
    function automatic int fifo_depth(input int logsize);
        return 1 << logsize;
    endfunction

endpackage

// File: rtl/sensor_fifo_ram.sv
// Storage for the sensor FIFO: synchronous write, asynchronous read so the
// head entry falls through to the output without a read cycle.
module sensor_fifo_ram
    import sensor_fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LOGSIZE = DEFAULT_LOGSIZE
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [LOGSIZE-1:0] waddr_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic [LOGSIZE-1:0] raddr_i,
    output logic [WIDTH-1:0]   rdata_o
);

    localparam int DEPTH = fifo_depth(LOGSIZE);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sensor_fifo_sync.sv
// Synchronous first-word fall-through FIFO with occupancy, threshold flags,
// flush and sticky error flags. Define SENSOR_FIFO_HWM_EN to add the hwm output.
module sensor_fifo_sync
    import sensor_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LOGSIZE   = DEFAULT_LOGSIZE,
    parameter int AF_THRESH = fifo_depth(LOGSIZE) - DEFAULT_AF_MARGIN,
    parameter int AE_THRESH = DEFAULT_AE_THRESH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               wr,
    input  logic [WIDTH-1:0]   din,
    input  logic               rd,
    output logic [WIDTH-1:0]   dout,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [LOGSIZE:0]   count,
    output logic               overflow,
    output logic               underflow,
    input  logic               clr_err
`ifdef SENSOR_FIFO_HWM_EN
    ,
    output logic [LOGSIZE:0]   hwm
`endif
);

    localparam int DEPTH = fifo_depth(LOGSIZE);
    localparam int PTR_W = clog2(DEPTH) + 1;

    // The extra pointer MSB separates a full FIFO from an empty one.
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [PTR_W-1:0] count_w;
    logic             rd_fire;
    logic             wr_fire;
    logic             overflow_set;
    logic             underflow_set;

    assign count_w      = wptr_q - rptr_q;
    assign full         = (count_w == PTR_W'(DEPTH));
    assign empty        = (count_w == '0);
    assign almost_full  = (count_w >= PTR_W'(AF_THRESH));
    assign almost_empty = (count_w <= PTR_W'(AE_THRESH));
    assign count        = count_w;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept a write.
    assign rd_fire       = rd & ~empty & ~flush;
    assign wr_fire       = wr & (~full | rd_fire) & ~flush;
    assign overflow_set  = wr & ~wr_fire & ~flush;
    assign underflow_set = rd & empty & ~flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = (clr_err ? 1'b0 : overflow_q) | overflow_set;
        underflow_d = (clr_err ? 1'b0 : underflow_q) | underflow_set;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_fire) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_fire) begin
                rptr_d = rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sensor_fifo_ram #(
        .WIDTH   (WIDTH),
        .LOGSIZE (LOGSIZE)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire & ~reset),
        .waddr_i (wptr_q[LOGSIZE-1:0]),
        .wdata_i (din),
        .raddr_i (rptr_q[LOGSIZE-1:0]),
        .rdata_o (dout)
    );

`ifdef SENSOR_FIFO_HWM_EN
    logic [PTR_W-1:0] hwm_q, hwm_d;

    // clr_err restarts tracking from the present occupancy rather than zero.
    always_comb begin
        hwm_d = hwm_q;
        if (clr_err) begin
            hwm_d = count_w;
        end else if (count_w > hwm_q) begin
            hwm_d = count_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_sensor_fifo_sync.sv
// Directed self-checking bench for sensor_fifo_sync (WIDTH=4, LOGSIZE=2, AF=3, AE=1).
module tb_sensor_fifo_sync;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       wr;
    logic [3:0] din;
    logic       rd;
    logic [3:0] dout;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;
`ifdef SENSOR_FIFO_HWM_EN
    logic [2:0] hwm;
`endif

    int total = 0;
    int bad   = 0;

    sensor_fifo_sync #(
        .WIDTH     (4),
        .LOGSIZE   (2),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
`ifdef SENSOR_FIFO_HWM_EN
        ,
        .hwm          (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [3:0] d, input logic r,
                       input logic f, input logic c);
        wr = w; din = d; rd = r; flush = f; clr_err = c;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; din = 4'h0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_afull"}, 32'(almost_full), 0);
        check({tag, "_aempty"}, 32'(almost_empty), 1);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_udf"}, 32'(underflow), 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wr = 1'b0; din = 4'h0; rd = 1'b0; clr_err = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        check_reset_state("reset");

        // Fill 1..4
        cyc(1, 4'd1, 0, 0, 0);
        check("fill1_count", 32'(count), 1);
        check("fill1_aempty", 32'(almost_empty), 1);
        check("fill1_dout", 32'(dout), 1);
        cyc(1, 4'd2, 0, 0, 0);
        check("fill2_count", 32'(count), 2);
        check("fill2_aempty", 32'(almost_empty), 0);
        check("fill2_afull", 32'(almost_full), 0);
        cyc(1, 4'd3, 0, 0, 0);
        check("fill3_count", 32'(count), 3);
        check("fill3_afull", 32'(almost_full), 1);
        check("fill3_full", 32'(full), 0);
        cyc(1, 4'd4, 0, 0, 0);
        check("fill4_count", 32'(count), 4);
        check("fill4_full", 32'(full), 1);
        check("fill4_ovf", 32'(overflow), 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_dout%0d", i), 32'(dout), 32'(i));
            cyc(0, 0, 1, 0, 0);
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);

        // Overflow: write 9 to a full FIFO, then set-wins against clr_err
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0, 0);
        cyc(1, 4'd9, 0, 0, 0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 4);
        cyc(1, 4'd9, 0, 0, 1);
        check("ovf_setwins", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_dout%0d", i), 32'(dout), 32'(i));
            cyc(0, 0, 1, 0, 0);
        end
        check("ovf_empty", 32'(empty), 1);
        cyc(0, 0, 0, 0, 1);
        check("ovf_clr", 32'(overflow), 0);

        // Full with simultaneous read and write of 5
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0, 0);
        cyc(1, 4'd5, 1, 0, 0);
        check("fullrw_count", 32'(count), 4);
        check("fullrw_ovf", 32'(overflow), 0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("fullrw_dout%0d", i), 32'(dout), 32'(i));
            cyc(0, 0, 1, 0, 0);
        end
        check("fullrw_empty", 32'(empty), 1);
        check("fullrw_udf", 32'(underflow), 0);

        // Empty with simultaneous read and write of 7
        cyc(1, 4'd7, 1, 0, 0);
        check("emptyrw_udf", 32'(underflow), 1);
        check("emptyrw_count", 32'(count), 1);
        check("emptyrw_dout", 32'(dout), 7);
        cyc(0, 0, 1, 0, 0);
        check("emptyrw_empty", 32'(empty), 1);
        cyc(0, 0, 0, 0, 1);
        check("emptyrw_clr", 32'(underflow), 0);

        // Wrap: alternating write/read pairs
        for (int i = 0; i < 10; i++) begin
            cyc(1, 4'(i), 0, 0, 0);
            check($sformatf("wrap_dout%0d", i), 32'(dout), 32'(i));
            check($sformatf("wrap_count%0d", i), 32'(count), 1);
            cyc(0, 0, 1, 0, 0);
        end
        check("wrap_empty", 32'(empty), 1);
        check("wrap_udf", 32'(underflow), 0);

        // Flush with 3 entries and overflow set; the write in the flush cycle is dropped
        for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0, 0);
        cyc(1, 4'd9, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("preflush_count", 32'(count), 3);
        check("preflush_ovf", 32'(overflow), 1);
        cyc(1, 4'd8, 0, 1, 0);
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_ovf", 32'(overflow), 1);
        cyc(0, 0, 0, 0, 0);
        check("flush_wrdropped", 32'(count), 0);

        // Reset mid-fill with a write pending; overflow is still set going in
        cyc(1, 4'd1, 0, 0, 0);
        cyc(1, 4'd2, 0, 0, 0);
        reset = 1'b1;
        cyc(1, 4'd3, 0, 0, 0);
        reset = 1'b0;
        check_reset_state("midreset");

`ifdef SENSOR_FIFO_HWM_EN
        for (int i = 1; i <= 3; i++) cyc(1, 4'(i), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("hwm_prefl", 32'(hwm), 3);
        cyc(0, 0, 0, 1, 0);
        check("hwm_flush", 32'(hwm), 3);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        reset = 1'b0;
        check("hwm_reset", 32'(hwm), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
